memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
Word-addressed memory unit that answers the CPU controller's read/write strobes on the memory side of the bus. It latches the MAR address and MDR write data when a request is accepted. After a programmable wait it performs the access and raises MFC. It holds MFC until the controller drops its strobe, giving a full four-phase handshake.

Parameters:
ADDR_WIDTH, 16, width of address input (driven from MAR)
DATA_WIDTH, 16, word width
DEPTH, 1024, number of storage words; valid addresses are 0..DEPTH-1
WAIT_CYCLES, 3, clock cycles from request acceptance to MFC assertion; legal range 1..15

Ports:
clock  in  1  system clock; all state updates on rising edge only
reset  in  1  asynchronous, active-low reset (reset==0 resets)
address  in  ADDR_WIDTH  word address from MAR
dataIn  in  DATA_WIDTH  write data from MDR
read  in  1  read strobe from controller, level, held until MFC seen
write  in  1  write strobe from controller, level, held until MFC seen
dataOut  out  DATA_WIDTH  read data toward DBUS/MDR
MFC  out  1  memory function complete
busy  out  1  high in any state other than IDLE
addrError  out  1  last accepted request addressed >= DEPTH
protoError  out  1  one-cycle pulse: read and write both high in IDLE

Behaviour:
- Reset (reset==0, async): state=IDLE, MFC=0, busy=0, dataOut=0, addrError=0, protoError=0, wait counter=0. Storage contents are not cleared. Reset during BUSY or DONE aborts the access; no write is committed.
- States: IDLE, BUSY, DONE.
- IDLE:
  - read XOR write high at an edge -> request accepted. Latch address, dataIn and op. Set addrError = (address >= DEPTH). Counter = WAIT_CYCLES-1. Go to BUSY.
  - read AND write both high -> no access, protoError=1 for one cycle, stay IDLE. Retry happens every edge while both stay high.
  - Neither high -> stay IDLE. protoError=0 everywhere except that pulse.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==0 and the accepted strobe is still high: perform the access and go to DONE with MFC=1.
    - Write: mem[latched addr] <= latched data, unless addrError.
    - Read: dataOut <= mem[latched addr], or 0 if addrError.
  - If the accepted strobe goes low during BUSY: go to IDLE, no access, MFC stays 0.
- Latency: request accepted at edge N gives MFC=1 after edge N+WAIT_CYCLES. With WAIT_CYCLES=1, MFC rises after the edge following acceptance.
- DONE:
  - MFC=1 and dataOut held stable.
  - When the accepted strobe is low at an edge: MFC=0, go to IDLE. dataOut keeps its last value.
  - A new request is only accepted from IDLE, so there is at least one idle edge between accesses.
  - If the opposite strobe rises while in DONE, it is ignored until IDLE.
- Strobe changes after acceptance do not affect the latched address or data.
- Address comparison is unsigned, full ADDR_WIDTH. Storage index uses the low ceil(log2(DEPTH)) bits, only when addrError=0.
- busy = (state != IDLE).

Test Plan:
- Write then read, WAIT_CYCLES=3: write=1, address=0x0010, dataIn=0xBEEF. MFC must rise 3 edges after acceptance; drop write and MFC falls next edge. Then read=1 at 0x0010: MFC after 3 edges with dataOut=0xBEEF, held until read drops.
- Out of range, DEPTH=1024: write 0x1234 to address 0x0400. addrError=1 and MFC still asserts. A read of 0x0400 returns 0x0000 with MFC. A read of 0x0000 shows its prior contents unchanged.
- Protocol error: read=1 and write=1 together in IDLE for 2 edges. protoError=1 each edge, busy=0, MFC=0, and no storage change.
- Abort: read accepted, then read dropped one edge later (WAIT_CYCLES=3). Responder returns to IDLE with MFC never asserting. A following write to the same address completes normally.
- Reset mid-write: write of 0xAAAA to 0x0005 accepted, then reset=0 one edge later. MFC=0, busy=0 immediately (async). A subsequent read of 0x0005 returns its pre-write value.
- Hold-off: keep read high for 5 edges after MFC. MFC and dataOut stay stable all 5 edges. After read drops, MFC=0 and busy=0 on the next edge, and no second access occurs.

Source files
------------

// File: rtl/memory_responder.sv
// Purpose: word-addressed memory slave answering controller read/write strobes with a four-phase MFC handshake.
// Latency: MFC rises WAIT_CYCLES edges after the request is accepted; dataOut is registered alongside MFC.
// Backpressure: MFC is held until the accepted strobe drops; new requests are only taken from IDLE.
module memory_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  read,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  MFC,
    output logic                  busy,
    output logic                  addrError,
    output logic                  protoError
);

    localparam int          IDXW    = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDXW-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  op_q, op_d;        // 1 = write, 0 = read
    logic                  aerr_q, aerr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  mfc_q, mfc_d;
    logic                  proto_q, proto_d;

    logic                  mem_we;
    logic                  strobe;
    logic                  addr_oor;

    // Storage is deliberately outside the reset domain: contents survive reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Full-width unsigned range check on the raw MAR address.
    assign addr_oor = (32'(address) >= DEPTH_L);

    // The strobe that belongs to the accepted request; the other one is ignored until IDLE.
    assign strobe = op_q ? write : read;

    // State and handshake registers; async reset aborts any in-flight access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= 1'b0;
            aerr_q  <= 1'b0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            aerr_q  <= aerr_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            proto_q <= proto_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, hold MFC in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        aerr_d  = aerr_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        proto_d = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (read && write) begin
                    // Ambiguous request: flag it and retry on the next edge.
                    proto_d = 1'b1;
                end else if (read || write) begin
                    addr_d  = address[IDXW-1:0];
                    data_d  = dataIn;
                    op_d    = write;
                    aerr_d  = addr_oor;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!strobe) begin
                    // Controller gave up: abandon without touching storage.
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    mfc_d   = 1'b1;
                    if (op_q) begin
                        mem_we = !aerr_q;
                    end else begin
                        dout_d = aerr_q ? '0 : mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!strobe) begin
                    mfc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit a write on the edge that completes the access.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign dataOut    = dout_q;
    assign MFC        = mfc_q;
    assign busy       = (state_q != IDLE);
    assign addrError  = aerr_q;
    assign protoError = proto_q;

endmodule

// File: tb/tb_memory_responder.sv
// Purpose: directed self-checking bench for memory_responder (default parameters).
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: every wait for MFC is bounded; an expired bound shows up as a wrong latency.
module tb_memory_responder;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic [15:0] dataIn;
    logic        read;
    logic        write;
    logic [15:0] dataOut;
    logic        MFC;
    logic        busy;
    logic        addrError;
    logic        protoError;

    int checks   = 0;
    int failures = 0;

    memory_responder #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .DEPTH      (1024),
        .WAIT_CYCLES(3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .dataIn    (dataIn),
        .read      (read),
        .write     (write),
        .dataOut   (dataOut),
        .MFC       (MFC),
        .busy      (busy),
        .addrError (addrError),
        .protoError(protoError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise one strobe, let it be accepted, then count edges until MFC (bounded).
    task automatic access(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                          output int lat);
        address = a;
        dataIn  = d;
        write   = is_wr;
        read    = !is_wr;
        tick();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (MFC) break;
        end
    endtask

    // Drop strobes; MFC must fall on the very next edge.
    task automatic release_strobe(input string tag);
        read  = 1'b0;
        write = 1'b0;
        tick();
        chk({tag, "_mfc_low"}, 32'(MFC), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        reset   = 1'b0;
        address = '0;
        dataIn  = '0;
        read    = 1'b0;
        write   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_mfc", 32'(MFC), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dataOut), 32'd0);
        chk("rst_aerr", 32'(addrError), 32'd0);
        chk("rst_perr", 32'(protoError), 32'd0);
        reset = 1'b1;
        tick();

        // Write then read with latency 3
        access(1'b1, 16'h0010, 16'hBEEF, lat);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_aerr", 32'(addrError), 32'd0);
        release_strobe("wr");
        access(1'b0, 16'h0010, 16'h0000, lat);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_data", 32'(dataOut), 32'hBEEF);

        // Hold-off: read stays high 5 edges after MFC
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_mfc", 32'(MFC), 32'd1);
            chk("hold_data", 32'(dataOut), 32'hBEEF);
        end
        release_strobe("hold");
        tick();
        chk("hold_no_second", 32'(busy), 32'd0);
        chk("hold_dout_kept", 32'(dataOut), 32'hBEEF);

        // Out-of-range access must not alias onto index 0
        access(1'b1, 16'h0000, 16'h5555, lat);
        release_strobe("w0");
        access(1'b1, 16'h0400, 16'h1234, lat);
        chk("oor_wr_lat", 32'(lat), 32'd3);
        chk("oor_wr_aerr", 32'(addrError), 32'd1);
        release_strobe("oorw");
        access(1'b0, 16'h0400, 16'h0000, lat);
        chk("oor_rd_mfc", 32'(MFC), 32'd1);
        chk("oor_rd_data", 32'(dataOut), 32'h0000);
        chk("oor_rd_aerr", 32'(addrError), 32'd1);
        release_strobe("oorr");
        access(1'b0, 16'h0000, 16'h0000, lat);
        chk("idx0_data", 32'(dataOut), 32'h5555);
        chk("idx0_aerr", 32'(addrError), 32'd0);
        release_strobe("idx0");

        // Protocol error: both strobes for two edges
        address = 16'h0000;
        dataIn  = 16'hDEAD;
        read    = 1'b1;
        write   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("perr_pulse", 32'(protoError), 32'd1);
            chk("perr_busy", 32'(busy), 32'd0);
            chk("perr_mfc", 32'(MFC), 32'd0);
        end
        read  = 1'b0;
        write = 1'b0;
        tick();
        chk("perr_clear", 32'(protoError), 32'd0);
        access(1'b0, 16'h0000, 16'h0000, lat);
        chk("perr_nostore", 32'(dataOut), 32'h5555);
        release_strobe("perr");

        // Abort: read dropped one edge after acceptance
        address = 16'h0020;
        read    = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd1);
        read = 1'b0;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_mfc", 32'(MFC), 32'd0);
        repeat (3) begin
            tick();
            chk("abort_mfc_never", 32'(MFC), 32'd0);
        end
        access(1'b1, 16'h0020, 16'h7777, lat);
        chk("abort_wr_lat", 32'(lat), 32'd3);
        release_strobe("abw");
        access(1'b0, 16'h0020, 16'h0000, lat);
        chk("abort_rd_data", 32'(dataOut), 32'h7777);
        release_strobe("abr");

        // Reset mid-write keeps old contents
        access(1'b1, 16'h0005, 16'h1111, lat);
        release_strobe("pre5");
        address = 16'h0005;
        dataIn  = 16'hAAAA;
        write   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_mfc", 32'(MFC), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dout", 32'(dataOut), 32'd0);
        write = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        access(1'b0, 16'h0005, 16'h0000, lat);
        chk("mid_rst_lat", 32'(lat), 32'd3);
        chk("mid_rst_data", 32'(dataOut), 32'h1111);
        release_strobe("post5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
